// File: rtl/crc_ccitt_framer_if.sv
// Byte-stream handshake bundle (valid/ready/data/last) shared by the framer's
// upstream and downstream sides.
interface crc_ccitt_framer_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  // A beat transfers on a rising edge where valid && ready. The master holds
  // data/last stable while valid is high and ready is low; ready may be
  // asserted independently of valid.
  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/crc_ccitt_framer.sv
// Forwards payload bytes unchanged and appends the 16-bit CRC-CCITT (0x1021,
// MSB-first, no final XOR) of each frame, high byte first, after its last byte.
module crc_ccitt_framer #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  crc_ccitt_framer_if.slave          s,
  crc_ccitt_framer_if.master         m,
  output logic [15:0]                crc_value,
  output logic [15:0]                frame_count,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_CRC_HI = 2'd1,
    ST_CRC_LO = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        slot_free;
  logic        load;
  logic [7:0]  load_data;
  logic        load_last;
  logic        clear_valid;
  logic        frame_done;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign slot_free = !m.valid || m.ready;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_DATA;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    s.ready     = 1'b0;
    load        = 1'b0;
    load_data   = 8'h00;
    load_last   = 1'b0;
    clear_valid = 1'b0;
    frame_done  = 1'b0;
    crc_next    = crc;
    case (state)
      ST_DATA: begin
        s.ready = slot_free;
        if (s.valid && slot_free) begin
          load      = 1'b1;
          load_data = s.data;
          crc_next  = crc_step(crc, s.data);
          if (s.last) state_next = ST_CRC_HI;
        end else if (slot_free) begin
          clear_valid = 1'b1;
        end
      end
      ST_CRC_HI: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = crc[15:8];
          state_next = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = crc[7:0];
          load_last  = 1'b1;
          frame_done = 1'b1;
          crc_next   = CRC_INIT;
          state_next = ST_DATA;
        end
      end
      default: state_next = ST_DATA;
    endcase
  end

  // Output slot holds its byte while stalled; the CRC only moves on accepted input
  // or when the trailer completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m.valid     <= 1'b0;
      m.data      <= 8'h00;
      m.last      <= 1'b0;
      crc         <= CRC_INIT;
      crc_value   <= 16'h0000;
      frame_count <= 16'h0000;
    end else begin
      if (load) begin
        m.valid <= 1'b1;
        m.data  <= load_data;
        m.last  <= load_last;
      end else if (clear_valid) begin
        m.valid <= 1'b0;
      end
      crc <= crc_next;
      if (frame_done) begin
        crc_value   <= crc;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_crc_ccitt_framer.sv
// Drives two framers (CRC_INIT 0xFFFF and 0x0000) with the same byte stream and
// checks both output streams and status against a byte-level CRC reference.
module tb_crc_ccitt_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;
  logic        rdy_rand = 1'b0;

  logic [15:0] crc_value_a, crc_value_b, frame_count_a, frame_count_b;
  logic [1:0]  dbg_state_a, dbg_state_b;

  int vectors = 0;
  int miscompares = 0;
  int wait_cycles = 0;

  localparam int W = 17;
  logic [W-1:0] exp_q[$];
  logic [15:0]  run_a, run_b, exp_crc_a, exp_crc_b;
  int           exp_frames;

  crc_ccitt_framer_if s_if_a ();
  crc_ccitt_framer_if m_if_a ();
  crc_ccitt_framer_if s_if_b ();
  crc_ccitt_framer_if m_if_b ();

  assign s_if_a.valid = s_valid;
  assign s_if_a.data  = s_data;
  assign s_if_a.last  = s_last;
  assign s_if_b.valid = s_valid;
  assign s_if_b.data  = s_data;
  assign s_if_b.last  = s_last;
  assign m_if_a.ready = m_ready;
  assign m_if_b.ready = m_ready;

  crc_ccitt_framer #(.CRC_INIT(16'hFFFF)) dut_a (
    .clk(clk), .rst(rst), .s(s_if_a.slave), .m(m_if_a.master),
    .crc_value(crc_value_a), .frame_count(frame_count_a), .dbg_state(dbg_state_a)
  );

  crc_ccitt_framer #(.CRC_INIT(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .s(s_if_b.slave), .m(m_if_b.master),
    .crc_value(crc_value_b), .frame_count(frame_count_b), .dbg_state(dbg_state_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_step(input logic [15:0] c, input logic [7:0] d);
    int x;
    x = int'(c) ^ int'({d, 8'h00});
    repeat (8) x = ((x & 'h8000) != 0) ? ((x << 1) ^ 'h1021) : (x << 1);
    return x[15:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    run_a      = 16'hFFFF;
    run_b      = 16'h0000;
    exp_crc_a  = 16'h0000;
    exp_crc_b  = 16'h0000;
    exp_frames = 0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    exp_q.push_back({1'b0, d, d});
    run_a = ref_step(run_a, d);
    run_b = ref_step(run_b, d);
    if (l) begin
      exp_q.push_back({1'b0, run_a[15:8], run_b[15:8]});
      exp_q.push_back({1'b1, run_a[7:0], run_b[7:0]});
      exp_crc_a  = run_a;
      exp_crc_b  = run_b;
      exp_frames = exp_frames + 1;
      run_a      = 16'hFFFF;
      run_b      = 16'h0000;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic         stalled;
    logic [W-1:0] held;
    logic [W-1:0] got;
    logic [W-1:0] e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      got = {m_if_a.last, m_if_a.data, m_if_b.data};
      if (stalled) begin
        vectors++;
        if (m_if_a.valid !== 1'b1 || m_if_b.valid !== 1'b1 || got !== held) begin
          $display("FAIL stall_hold: got valid=%b/%b beat=%h required valid=1 beat=%h",
                   m_if_a.valid, m_if_b.valid, got, held);
          miscompares++;
        end
      end
      if (m_if_a.valid === 1'b1 && m_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: got beat=%h required no output", got);
          miscompares++;
        end else begin
          e = exp_q.pop_front();
          if (got !== e || m_if_b.valid !== 1'b1) begin
            $display("FAIL out_beat: got last=%b a=%h b=%h (b valid=%b) required last=%b a=%h b=%h",
                     got[16], got[15:8], got[7:0], m_if_b.valid, e[16], e[15:8], e[7:0]);
            miscompares++;
          end
        end
      end
      stalled = m_if_a.valid && !m_ready;
      held    = got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    n = 0;
    while (!s_if_a.ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      wait_cycles++;
    end
    if (!s_if_a.ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got s_ready=0 for %0d cycles required acceptance", n);
    end else begin
      model_accept(d, l);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_ascii();
    for (int i = 0; i < 9; i++) send_byte(8'(8'h31 + i), (i == 8));
  endtask

  task automatic send_random_frame(input int len);
    for (int i = 0; i < len; i++) send_byte(8'($urandom_range(0, 255)), (i == len - 1));
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;
    model_clear();
    @(negedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: got %0d beats outstanding required 0", name, exp_q.size());
      miscompares++;
    end
    vectors++;
    if (crc_value_a !== exp_crc_a || crc_value_b !== exp_crc_b) begin
      $display("FAIL %s_crc_value: got %h/%h required %h/%h", name,
               crc_value_a, crc_value_b, exp_crc_a, exp_crc_b);
      miscompares++;
    end
    vectors++;
    if (frame_count_a !== 16'(exp_frames) || frame_count_b !== 16'(exp_frames)) begin
      $display("FAIL %s_frame_count: got %0d/%0d required %0d", name,
               frame_count_a, frame_count_b, exp_frames);
      miscompares++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_clear();
    @(negedge clk);
    #1;
    vectors++;
    if (m_if_a.valid !== 1'b0 || m_if_a.data !== 8'h00 || m_if_a.last !== 1'b0 ||
        m_if_b.valid !== 1'b0 || m_if_b.data !== 8'h00 || m_if_b.last !== 1'b0) begin
      $display("FAIL reset_outputs: got v=%b d=%h l=%b required v=0 d=00 l=0",
               m_if_a.valid, m_if_a.data, m_if_a.last);
      miscompares++;
    end
    vectors++;
    if (crc_value_a !== 16'h0 || frame_count_a !== 16'h0 || crc_value_b !== 16'h0 ||
        frame_count_b !== 16'h0) begin
      $display("FAIL reset_status: got crc=%h cnt=%h required 0000/0000", crc_value_a, frame_count_a);
      miscompares++;
    end
    vectors++;
    if (dbg_state_a !== 2'd0 || s_if_a.ready !== 1'b1) begin
      $display("FAIL reset_state: got state=%0d s_ready=%b required 0/1", dbg_state_a, s_if_a.ready);
      miscompares++;
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_ascii();
    rdy_rand = 1'b0;
    send_ascii();
    drain_and_check("ascii");
    vectors++;
    if (crc_value_a !== 16'h29B1 || crc_value_b !== 16'h31C3) begin
      $display("FAIL ascii_check_value: got %h/%h required 29b1/31c3", crc_value_a, crc_value_b);
      miscompares++;
    end
  endtask

  task automatic test_single_byte();
    send_byte(8'h00, 1'b1);
    drain_and_check("single_00");
    vectors++;
    if (crc_value_a !== 16'hE1F0) begin
      $display("FAIL single_00_value: got %h required e1f0", crc_value_a);
      miscompares++;
    end
    send_byte(8'h01, 1'b1);
    drain_and_check("single_01");
    vectors++;
    if (crc_value_b !== 16'h1021) begin
      $display("FAIL single_01_value: got %h required 1021", crc_value_b);
      miscompares++;
    end
  endtask

  task automatic test_throughput();
    rdy_rand    = 1'b0;
    wait_cycles = 0;
    for (int f = 0; f < 3; f++) send_random_frame(int'($urandom_range(1, 6)));
    vectors++;
    if (wait_cycles != 4) begin
      $display("FAIL throughput_waits: got %0d refused cycles required 4", wait_cycles);
      miscompares++;
    end
    drain_and_check("throughput");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rdy_rand = 1'b1;
    send_ascii();
    send_random_frame(int'($urandom_range(1, 12)));
    send_ascii();
    drain_and_check("back_to_back");
    rdy_rand = 1'b0;
    vectors++;
    if (frame_count_a !== 16'd3 || crc_value_a !== 16'h29B1) begin
      $display("FAIL back_to_back_final: got cnt=%0d crc=%h required 3/29b1", frame_count_a, crc_value_a);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_frame();
    rdy_rand = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 1'b0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (m_if_a.valid !== 1'b0 || m_if_a.data !== 8'h00 || m_if_a.last !== 1'b0 ||
        crc_value_a !== 16'h0 || frame_count_a !== 16'h0 || dbg_state_a !== 2'd0) begin
      $display("FAIL midreset_outputs: got v=%b d=%h crc=%h cnt=%h required 0/00/0000/0000",
               m_if_a.valid, m_if_a.data, crc_value_a, frame_count_a);
      miscompares++;
    end
    model_clear();
    @(negedge clk);
    #3 rst = 1'b0;
    send_ascii();
    drain_and_check("midreset");
    vectors++;
    if (crc_value_a !== 16'h29B1 || crc_value_b !== 16'h31C3 || frame_count_a !== 16'd1) begin
      $display("FAIL midreset_final: got crc=%h/%h cnt=%0d required 29b1/31c3/1",
               crc_value_a, crc_value_b, frame_count_a);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_ascii();
    test_single_byte();
    test_throughput();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
